uart_receive: RTL and testbench
===============================

UART_RECEIVE -- requirements
Module: uart_receive

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (1..15).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, i_clk cycles per bit period (even, >=4).
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line; idle high.
REQ-006 SHALL have port i_ack  input  1  consumer acknowledge; clears o_valid.
REQ-007 SHALL have port rx_data  output  DATA_BITS  last committed byte.
REQ-008 SHALL have port o_valid  output  1  high while rx_data holds an unacknowledged byte.
REQ-009 SHALL have port o_frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port o_overrun  output  1  one-cycle pulse when a completed byte is dropped.
REQ-011 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rx_s.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: rx_s==0 SHALL move to START with bit-cycle counter cleared.
REQ-015 START: at counter==CLKS_PER_BIT/2-1 SHALL sample rx_s; 0 -> DATA (counter and bit index cleared); 1 -> IDLE (glitch rejected, no output activity).
REQ-016 DATA: at counter==CLKS_PER_BIT-1 SHALL sample rx_s into bit position bit_index (LSB first), clear counter, increment bit_index; after sample DATA_BITS-1 SHALL go to STOP.
REQ-017 STOP: at counter==CLKS_PER_BIT-1 SHALL sample rx_s; 1 -> commit (REQ-019) and IDLE; 0 -> pulse o_frame_err, no commit, go to WAIT_HIGH.
REQ-018 WAIT_HIGH: SHALL remain until rx_s==1, then IDLE; no new frame is recognized before that.
REQ-019 Commit SHALL occur on the cycle after the stop sample: if o_valid==0, or i_ack==1 that cycle, rx_data loads the shift register and o_valid is 1; otherwise the new byte is discarded, rx_data is unchanged, and o_overrun pulses.
REQ-020 i_ack with o_valid==1 and no same-cycle commit SHALL clear o_valid next cycle; i_ack with o_valid==0 SHALL be ignored.
REQ-021 rx_data SHALL change only on commit; o_valid SHALL be a level, not a pulse.
REQ-022 Counters SHALL be sized ceil(log2(CLKS_PER_BIT)) and ceil(log2(DATA_BITS+1)) bits; no wrap occurs within a frame.
REQ-023 Sample points SHALL be at mid-bit: the first data sample is 1.5 bit periods (+ synchronizer latency of 2 cycles) after the falling start edge.
REQ-024 o_frame_err and o_overrun SHALL never assert in the same cycle.

Reset
REQ-025 i_rst high at a clock edge SHALL force state IDLE, counters 0, shift register 0, rx_data 0, o_valid 0, o_frame_err 0, o_overrun 0, o_busy 0, synchronizer flops 1.
REQ-026 Reset mid-frame SHALL abandon the frame with no commit or error; after release, reception resumes at the next falling edge of rx_s.
REQ-027 i_rst SHALL take priority over i_ack and all state transitions.

Verification (DATA_BITS=8, CLKS_PER_BIT=16)
REQ-028 Frame 0xA5, good stop bit -> rx_data=0xA5, o_valid=1 about 150 cycles after the start edge, held until i_ack; o_valid=0 the cycle after i_ack.
REQ-029 rx low for 4 cycles, then high -> return to IDLE, o_valid, o_frame_err and o_overrun stay 0.
REQ-030 Frame 0x3C with stop bit 0 -> single o_frame_err pulse, o_valid stays 0, o_busy=1 until rx returns high.
REQ-031 Frames 0x11 then 0x22, no i_ack -> rx_data=0x11, o_valid=1, one o_overrun pulse at the second commit; repeat with i_ack on the commit cycle -> rx_data=0x22, o_valid=1, no o_overrun.
REQ-032 i_rst pulsed during bit 4 of 0xFF, then frame 0x0F sent -> no output from the aborted frame; rx_data=0x0F, o_valid=1.
REQ-033 Back-to-back frames 0x00, 0xFF, 0x55 with one stop bit each, i_ack after each -> all three bytes committed in order; no error pulses.

Source files
------------

// File: rtl/uart_receive.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, LSB-first, one stop bit.
// Completed bytes are held in rx_data with a valid/ack handshake; drops flag o_overrun.
module uart_receive #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 rx,
  input  logic                 i_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_t;

  state_t                 r_state;
  logic                   r_rx_meta;
  logic                   r_rx_s;
  logic [CntW-1:0]        r_cnt;
  logic [IdxW-1:0]        r_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_commit;
  logic                   r_valid;
  logic                   r_frame_err;
  logic                   r_overrun;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_commit    <= 1'b0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rx_meta   <= rx;
      r_rx_s      <= r_rx_meta;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_commit    <= 1'b0;

      case (r_state)
        StIdle: begin
          if (!r_rx_s) begin
            r_state <= StStart;
            r_cnt   <= '0;
          end
        end
        StStart: begin
          if (r_cnt == CntHalf) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_state <= StData;
              r_idx   <= '0;
            end else begin
              r_state <= StIdle;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StData: begin
          if (r_cnt == CntLast) begin
            r_cnt <= '0;
            for (int unsigned i = 0; i < DATA_BITS; i++) begin
              if (r_idx == IdxW'(i)) r_shift[i] <= r_rx_s;
            end
            r_idx <= r_idx + 1'b1;
            if (r_idx == IdxLast) r_state <= StStop;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StStop: begin
          if (r_cnt == CntLast) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_commit <= 1'b1;
              r_state  <= StIdle;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= StWaitHigh;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StWaitHigh: begin
          if (r_rx_s) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase

      // A same-cycle ack frees the holding register for the incoming byte.
      if (r_commit) begin
        if (!r_valid || i_ack) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (i_ack && r_valid) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data     = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;
  assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_uart_receive.sv
// Scoreboard bench for uart_receive (8 data bits, 16 clocks per bit).
module tb_uart_receive;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       ack_man;
  logic       ack_auto = 1'b0;
  logic       i_ack;
  logic [7:0] rx_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  assign i_ack = ack_man | ack_auto;

  uart_receive #(
    .DATA_BITS   (8),
    .CLKS_PER_BIT(16)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .rx         (rx),
    .i_ack      (i_ack),
    .rx_data    (rx_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         commit_cyc = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         both_cnt = 0;
  int         fe0;
  int         ov0;
  bit         prev_valid = 1'b0;
  bit         prev_ack = 1'b0;
  bit         auto_ack = 1'b0;
  logic [7:0] sb_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // A commit shows as o_valid rising, or o_valid staying high across an ack.
  always @(negedge clk) begin
    if (o_valid === 1'b1 && (!prev_valid || prev_ack)) begin
      commit_cyc = cyc;
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) check("rx_data_commit", 32'(rx_data), 32'(sb_q.pop_front()));
    end
    if (o_frame_err === 1'b1) fe_cnt++;
    if (o_overrun === 1'b1) ov_cnt++;
    if (o_frame_err === 1'b1 && o_overrun === 1'b1) both_cnt++;
    ack_auto   = auto_ack && (o_valid === 1'b1);
    prev_valid = (o_valid === 1'b1);
    prev_ack   = ack_man | ack_auto;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    @(posedge clk);
    #1;
    rx = 1'b0;
    start_cyc = cyc;
    repeat (16) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    @(posedge clk);
    #1 ack_man = 1'b1;
    @(posedge clk);
    #1 ack_man = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    rx      = 1'b1;
    ack_man = 1'b0;
    idle(3);
    @(negedge clk);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_frame_err", 32'(o_frame_err), 32'd0);
    check("rst_overrun", 32'(o_overrun), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(5);

    // Good frame, latency, hold until ack
    sb_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(10);
    @(negedge clk);
    check("a5_valid", 32'(o_valid), 32'd1);
    check("a5_data", 32'(rx_data), 32'hA5);
    check("a5_latency", 32'(commit_cyc - start_cyc), 32'd156);
    idle(30);
    @(negedge clk);
    check("a5_valid_held", 32'(o_valid), 32'd1);
    pulse_ack();
    @(negedge clk);
    check("a5_valid_after_ack", 32'(o_valid), 32'd0);
    check("a5_data_after_ack", 32'(rx_data), 32'hA5);

    // Start glitch rejected
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    @(negedge clk);
    check("glitch_busy", 32'(o_busy), 32'd1);
    idle(30);
    @(negedge clk);
    check("glitch_idle", 32'(o_busy), 32'd0);
    check("glitch_valid", 32'(o_valid), 32'd0);
    check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);
    check("glitch_ov", 32'(ov_cnt - ov0), 32'd0);

    // Bad stop bit
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    idle(20);
    @(negedge clk);
    check("ferr_busy_low", 32'(o_busy), 32'd1);
    check("ferr_pulse", 32'(fe_cnt - fe0), 32'd1);
    check("ferr_valid", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1 rx = 1'b1;
    idle(10);
    @(negedge clk);
    check("ferr_busy_high", 32'(o_busy), 32'd0);
    check("ferr_single", 32'(fe_cnt - fe0), 32'd1);

    // Overrun without ack, then commit with same-cycle ack
    ov0 = ov_cnt;
    sb_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    idle(5);
    send_frame(8'h22, 1'b1);
    idle(10);
    @(negedge clk);
    check("ovr_pulse", 32'(ov_cnt - ov0), 32'd1);
    check("ovr_data_kept", 32'(rx_data), 32'h11);
    check("ovr_valid", 32'(o_valid), 32'd1);
    sb_q.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(posedge clk);
        repeat (155) @(posedge clk);
        #1 ack_man = 1'b1;
        @(posedge clk);
        #1 ack_man = 1'b0;
      end
    join
    idle(10);
    @(negedge clk);
    check("ackc_no_ovr", 32'(ov_cnt - ov0), 32'd1);
    check("ackc_data", 32'(rx_data), 32'h22);
    check("ackc_valid", 32'(o_valid), 32'd1);
    pulse_ack();
    @(negedge clk);
    check("ackc_cleared", 32'(o_valid), 32'd0);

    // Reset mid-frame during bit 4 of 0xFF
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(posedge clk);
        repeat (16 * 5 + 8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    idle(10);
    @(negedge clk);
    check("abort_valid", 32'(o_valid), 32'd0);
    check("abort_data", 32'(rx_data), 32'h0);
    check("abort_busy", 32'(o_busy), 32'd0);
    sb_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    idle(10);
    @(negedge clk);
    check("resume_data", 32'(rx_data), 32'h0F);
    check("resume_valid", 32'(o_valid), 32'd1);
    check("abort_fe", 32'(fe_cnt - fe0), 32'd0);
    check("abort_ov", 32'(ov_cnt - ov0), 32'd0);
    pulse_ack();

    // Back-to-back frames with acknowledge after each
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    auto_ack = 1'b1;
    sb_q.push_back(8'h00);
    sb_q.push_back(8'hFF);
    sb_q.push_back(8'h55);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    idle(20);
    auto_ack = 1'b0;
    @(negedge clk);
    check("b2b_last_data", 32'(rx_data), 32'h55);
    check("b2b_valid_acked", 32'(o_valid), 32'd0);
    check("b2b_fe", 32'(fe_cnt - fe0), 32'd0);
    check("b2b_ov", 32'(ov_cnt - ov0), 32'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("err_exclusive", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
